// File: rtl/sysid_pkg.sv
// -----------------------------------------------------------------------------
// sysid_pkg
// Shared definitions for the system-ID register slave: word offsets of the
// register map, CAPS bit positions, VERSION field positions and small helpers
// for byte-lane merging and CAPS word assembly.
// -----------------------------------------------------------------------------
package sysid_pkg;

  // Register map word offsets
  localparam int REG_ID        = 0;
  localparam int REG_TIMESTAMP = 1;
  localparam int REG_VERSION   = 2;
  localparam int REG_CAPS      = 3;
  localparam int REG_SCRATCH   = 4;
  localparam int REG_UPTIME_LO = 5;
  localparam int REG_UPTIME_HI = 6;
  localparam int REG_RSVD      = 7;
  localparam int REG_USER0     = 8;

  // CAPS bit positions
  localparam int CAPS_NUSER_LSB  = 0;
  localparam int CAPS_UPTIME_BIT = 8;

  // VERSION field positions
  localparam int VER_MAJOR_LSB = 16;
  localparam int VER_MINOR_LSB = 8;
  localparam int VER_PATCH_LSB = 0;

  // Replace the byte lanes of old_v selected by be with those of new_v
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    be_merge = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        be_merge[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        be_merge[8*b +: 8] = old_v[8*b +: 8];
      end
    end
  endfunction

  // Assemble the capability word from the user-word count and uptime flag
  function automatic logic [31:0] caps_word(input int   num_user,
                                            input logic uptime_present);
    caps_word = 32'h0000_0000;
    caps_word[CAPS_NUSER_LSB +: 8] = num_user[7:0];
    caps_word[CAPS_UPTIME_BIT]     = uptime_present;
  endfunction

endpackage

// File: rtl/sysid_uptime_cnt.sv
// -----------------------------------------------------------------------------
// sysid_uptime_cnt
// Free-running 64-bit cycle counter with a high-word shadow. When snap is
// high the live high word is captured, so the low word read in the same cycle
// and a later read of the shadow form one coherent 64-bit sample.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   snap       in   capture live high word into hi_shadow
//   lo         out  live low word of the counter
//   hi_shadow  out  captured high word
// -----------------------------------------------------------------------------
module sysid_uptime_cnt (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        snap,
  output logic [31:0] lo,
  output logic [31:0] hi_shadow
);

  logic [63:0] r_cnt;
  logic [31:0] r_hi_shadow;

  // Counter increments every cycle and wraps naturally at 2^64
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 64'h0;
    end else begin
      r_cnt <= r_cnt + 64'd1;
    end
  end

  // High-word shadow captured on a low-word read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi_shadow <= 32'h0;
    end else if (snap) begin
      r_hi_shadow <= r_cnt[63:32];
    end else begin
      r_hi_shadow <= r_hi_shadow;
    end
  end

  assign lo        = r_cnt[31:0];
  assign hi_shadow = r_hi_shadow;

endmodule

// File: rtl/sysid_regs.sv
// -----------------------------------------------------------------------------
// sysid_regs
// System-ID / build-info slave on Avalon-MM with fixed one-cycle read latency.
// Map: 0 SYSTEM_ID, 1 TIMESTAMP, 2 VERSION, 3 CAPS, 4 SCRATCH (RW, byte
// enables), 5 UPTIME_LO, 6 UPTIME_HI, 7 reserved, 8.. user ID words.
// Optional feature macro: SYSID_UPTIME_EN builds the 64-bit uptime counter;
// without it UPTIME_LO/HI read 0 and CAPS[8] is 0.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address, read, write  word address and strobes (read wins on collision)
//   writedata, byteenable write data and byte lanes
//   readdata              registered read data, held between responses
//   readdatavalid         one-cycle pulse with each response
//   user_id               NUM_USER static 32-bit words, word k at [32k+31:32k]
// -----------------------------------------------------------------------------
module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID = 32'h6341_0175,
  parameter logic [31:0] TIMESTAMP = 32'h51FE_0E5D,
  parameter logic [31:0] VERSION   = 32'h0001_0000,
  parameter int          NUM_USER  = 4,
  parameter int          ADDR_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         address,
  input  logic                      read,
  input  logic                      write,
  input  logic [31:0]               writedata,
  input  logic [3:0]                byteenable,
  output logic [31:0]               readdata,
  output logic                      readdatavalid,
  input  logic [((NUM_USER > 0) ? 32*NUM_USER : 32)-1:0] user_id
);

`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif

  localparam logic [31:0] CAPS_VALUE = caps_word(NUM_USER, UPTIME_PRESENT);

  logic [31:0] r_scratch;
  logic [31:0] w_rdata;
  logic [31:0] w_up_lo;
  logic [31:0] w_up_hi;
  logic        w_scratch_we;
  logic        w_snap;

  // A write colliding with a read is dropped
  assign w_scratch_we = write & ~read & (address == ADDR_W'(REG_SCRATCH));
  assign w_snap       = read & (address == ADDR_W'(REG_UPTIME_LO));

`ifdef SYSID_UPTIME_EN
  sysid_uptime_cnt u_uptime (
    .clk       (clk),
    .reset_n   (reset_n),
    .snap      (w_snap),
    .lo        (w_up_lo),
    .hi_shadow (w_up_hi)
  );
`else
  assign w_up_lo = 32'h0;
  assign w_up_hi = 32'h0;
  logic w_unused;
  assign w_unused = w_snap;
`endif

  // Scratch register, byte-lane writable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scratch <= 32'h0;
    end else if (w_scratch_we) begin
      r_scratch <= be_merge(r_scratch, writedata, byteenable);
    end else begin
      r_scratch <= r_scratch;
    end
  end

  // Read-data selection; anything not decoded reads zero
  always_comb begin
    w_rdata = 32'h0;
    case (address)
      ADDR_W'(REG_ID):        w_rdata = SYSTEM_ID;
      ADDR_W'(REG_TIMESTAMP): w_rdata = TIMESTAMP;
      ADDR_W'(REG_VERSION):   w_rdata = VERSION;
      ADDR_W'(REG_CAPS):      w_rdata = CAPS_VALUE;
      ADDR_W'(REG_SCRATCH):   w_rdata = r_scratch;
      ADDR_W'(REG_UPTIME_LO): w_rdata = w_up_lo;
      ADDR_W'(REG_UPTIME_HI): w_rdata = w_up_hi;
      ADDR_W'(REG_RSVD):      w_rdata = 32'h0;
      default: begin
        for (int k = 0; k < NUM_USER; k++) begin
          if (address == ADDR_W'(REG_USER0 + k)) begin
            w_rdata = user_id[32*k +: 32];
          end else begin
            w_rdata = w_rdata;
          end
        end
      end
    endcase
  end

  // Registered read response; readdata holds between responses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= 32'h0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) begin
        readdata <= w_rdata;
      end else begin
        readdata <= readdata;
      end
    end
  end

endmodule
